// File: rtl/rr_arbiter_4.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter_4
//  Brief    : Four-requester arbiter with a registered one-hot grant.
//             Round-robin or fixed priority, a hold limit per grant, and a
//             timeout pulse when the hold limit revokes a grant.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter_4 #(
  parameter int RR       = 1,   // 1: round-robin, 0: fixed priority (index 0 highest)
  parameter int MAX_HOLD = 16   // maximum consecutive grant cycles, 1..255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_v,
  output logic       timeout
);

  localparam logic [0:0] c_IDLE      = 1'b0;
  localparam logic [0:0] c_BUSY      = 1'b1;
  localparam logic [7:0] c_HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [0:0] r_state;
  logic [3:0] r_gnt;
  logic [1:0] r_gnt_id;
  logic       r_gnt_v;
  logic       r_timeout;
  logic [7:0] r_cnt;
  logic [1:0] r_last;

  logic [1:0] w_start;
  logic [7:0] w_req2;
  logic [3:0] w_rot;
  logic [1:0] w_off;
  logic [1:0] w_win_id;
  logic       w_rel_hold;
  logic       w_rel_other;

  // Search start: one past the most recent grant, or always index 0.
  generate
    if (RR != 0) begin : g_round_robin
      assign w_start = r_last + 2'd1;
    end else begin : g_fixed_priority
      assign w_start = 2'd0;
    end
  endgenerate

  // Rotate requests so the search start lands on bit 0, then take the lowest set bit.
  assign w_req2 = {req, req};
  assign w_rot  = w_req2[w_start +: 4];

  // Priority encoder on the rotated request vector.
  always_comb begin
    w_off = 2'd3;
    if (w_rot[0])      w_off = 2'd0;
    else if (w_rot[1]) w_off = 2'd1;
    else if (w_rot[2]) w_off = 2'd2;
  end

  assign w_win_id = w_start + w_off;

  // Release conditions while a grant is held; the hold limit alone raises timeout.
  assign w_rel_hold  = (r_cnt == c_HOLD_LAST);
  assign w_rel_other = done | ~req[r_gnt_id];

  // Grant FSM: IDLE issues a grant, BUSY holds it until a release condition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_IDLE;
      r_gnt     <= 4'd0;
      r_gnt_id  <= 2'd0;
      r_gnt_v   <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= 8'd0;
      r_last    <= 2'd3;
    end else if (r_state == c_IDLE) begin
      r_timeout <= 1'b0;
      r_cnt     <= 8'd0;
      if (|req) begin
        r_state  <= c_BUSY;
        r_gnt    <= 4'b0001 << w_win_id;
        r_gnt_id <= w_win_id;
        r_gnt_v  <= 1'b1;
        r_last   <= w_win_id;
      end
    end else begin
      if (w_rel_hold | w_rel_other) begin
        r_state   <= c_IDLE;
        r_gnt     <= 4'd0;
        r_gnt_v   <= 1'b0;
        r_cnt     <= 8'd0;
        r_timeout <= w_rel_hold & ~w_rel_other;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign gnt     = r_gnt;
  assign gnt_id  = r_gnt_id;
  assign gnt_v   = r_gnt_v;
  assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_arbiter_4
//  Brief    : Bench for rr_arbiter_4. Three instances (round-robin/16,
//             fixed-priority/4, round-robin/1) share one stimulus and are
//             compared every cycle against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_4;

  localparam int c_RRP [3] = '{1, 0, 1};
  localparam int c_MHP [3] = '{16, 4, 1};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt_w     [3];
  logic [1:0] gnt_id_w  [3];
  logic       gnt_v_w   [3];
  logic       timeout_w [3];

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  check_en = 1'b0;

  // Model state: owner index (-1 when idle), cycles held so far, last grant.
  int  m_owner [3];
  int  m_held  [3];
  int  m_last  [3];
  int  m_id    [3];
  bit  m_to    [3];

  always #5 clk = ~clk;

  rr_arbiter_4 #(.RR(1), .MAX_HOLD(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt_w[0]), .gnt_id(gnt_id_w[0]), .gnt_v(gnt_v_w[0]), .timeout(timeout_w[0])
  );

  rr_arbiter_4 #(.RR(0), .MAX_HOLD(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt_w[1]), .gnt_id(gnt_id_w[1]), .gnt_v(gnt_v_w[1]), .timeout(timeout_w[1])
  );

  rr_arbiter_4 #(.RR(1), .MAX_HOLD(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt_w[2]), .gnt_id(gnt_id_w[2]), .gnt_v(gnt_v_w[2]), .timeout(timeout_w[2])
  );

  // Winner selection straight from the arbitration rules.
  function automatic int pick(input int rr, input int last, input logic [3:0] r);
    int w;
    w = -1;
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = rr ? ((last + k) % 4) : (k - 1);
      if (w < 0 && r[idx]) w = idx;
    end
    return w;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model: one step per clock, asynchronous reset.
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_owner[i] <= -1;
        m_held[i]  <= 0;
        m_last[i]  <= 3;
        m_id[i]    <= 0;
        m_to[i]    <= 1'b0;
      end else if (m_owner[i] < 0) begin
        m_to[i] <= 1'b0;
        if (req != 4'd0) begin
          m_owner[i] <= pick(c_RRP[i], m_last[i], req);
          m_id[i]    <= pick(c_RRP[i], m_last[i], req);
          m_last[i]  <= pick(c_RRP[i], m_last[i], req);
          m_held[i]  <= 1;
        end
      end else if (done || !req[m_owner[i]] || m_held[i] == c_MHP[i]) begin
        m_owner[i] <= -1;
        m_to[i]    <= (m_held[i] == c_MHP[i]) && !done && req[m_owner[i]];
      end else begin
        m_held[i] <= m_held[i] + 1;
      end
    end
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("gnt[%0d]", i), int'(gnt_w[i]), (m_owner[i] < 0) ? 0 : (1 << m_owner[i]));
        chk($sformatf("gnt_v[%0d]", i), int'(gnt_v_w[i]), (m_owner[i] < 0) ? 0 : 1);
        chk($sformatf("gnt_id[%0d]", i), int'(gnt_id_w[i]), m_id[i]);
        chk($sformatf("timeout[%0d]", i), int'(timeout_w[i]), int'(m_to[i]));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'd0;
    done  = 1'b0;
    repeat (3) @(negedge clk);
    check_en = 1'b1;
    #1;
    chk("lit_reset_gnt", int'(gnt_w[0]), 0);
    chk("lit_reset_gnt_id", int'(gnt_id_w[0]), 0);
    chk("lit_reset_gnt_v", int'(gnt_v_w[0]), 0);
    chk("lit_reset_timeout", int'(timeout_w[0]), 0);

    // Round-robin from reset: 1010 grants 1, then 3 after a done release.
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b1010;
    @(negedge clk); #1;
    chk("lit_rr_first_gnt", int'(gnt_w[0]), 4'b0010);
    chk("lit_rr_first_id", int'(gnt_id_w[0]), 1);
    chk("lit_fp_first_gnt", int'(gnt_w[1]), 4'b0010);
    done = 1'b1;
    @(negedge clk); #1;
    chk("lit_rr_idle_gnt", int'(gnt_w[0]), 0);
    done = 1'b0;
    @(negedge clk); #1;
    chk("lit_rr_second_gnt", int'(gnt_w[0]), 4'b1000);
    chk("lit_rr_second_id", int'(gnt_id_w[0]), 3);
    chk("lit_fp_second_gnt", int'(gnt_w[1]), 4'b0010);

    // Owner drops its request: release without timeout.
    req = 4'b0000;
    @(negedge clk); #1;
    chk("lit_drop_gnt", int'(gnt_w[0]), 0);
    chk("lit_drop_timeout", int'(timeout_w[0]), 0);

    // Hold limit: 16 cycles of 0001, then timeout, then grant to 1.
    req = 4'b1111;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk); #1;
      if (k == 1 || k == 16) chk($sformatf("lit_hold_gnt_c%0d", k), int'(gnt_w[0]), 4'b0001);
    end
    @(negedge clk); #1;
    chk("lit_hold_end_gnt", int'(gnt_w[0]), 0);
    chk("lit_hold_timeout", int'(timeout_w[0]), 1);
    @(negedge clk); #1;
    chk("lit_next_gnt", int'(gnt_w[0]), 4'b0010);
    chk("lit_next_timeout", int'(timeout_w[0]), 0);

    // Move to owner 2, then assert reset mid-grant.
    req = 4'b0100;
    @(negedge clk); #1;
    chk("lit_handoff_gnt", int'(gnt_w[0]), 0);
    @(negedge clk); #1;
    chk("lit_own2_gnt", int'(gnt_w[0]), 4'b0100);
    #1 rst_n = 1'b0;
    #1;
    chk("lit_async_rst_gnt", int'(gnt_w[0]), 0);
    chk("lit_async_rst_gnt_v", int'(gnt_v_w[0]), 0);
    chk("lit_async_rst_timeout", int'(timeout_w[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b1000;
    @(negedge clk); #1;
    chk("lit_post_rst_gnt", int'(gnt_w[0]), 4'b1000);
    chk("lit_post_rst_id", int'(gnt_id_w[0]), 3);
    chk("lit_mh1_gnt", int'(gnt_w[2]), 4'b1000);
    // done together with the hold limit on the single-cycle instance.
    done = 1'b1;
    @(negedge clk); #1;
    chk("lit_mh1_done_gnt", int'(gnt_w[2]), 0);
    chk("lit_mh1_done_timeout", int'(timeout_w[2]), 0);
    done = 1'b0;
    @(negedge clk); #1;
    chk("lit_mh1_regrant", int'(gnt_w[2]), 4'b1000);
    @(negedge clk); #1;
    chk("lit_mh1_limit_timeout", int'(timeout_w[2]), 1);

    // Randomized traffic; requests mostly stable so hold limits are reached.
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk); #1;
      if ($urandom_range(7) == 0) req = 4'($urandom);
      done = ($urandom_range(15) == 0);
    end

    @(negedge clk);
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
